seq_addsub_16: RTL
==================

# seq_addsub_16

Multi-cycle 16-bit adder/subtractor that processes one 4-bit carry-lookahead slice per clock, rippling the carry through a registered carry flop over four cycles. It sits beside the combinational 16-bit CLA adder as the area-reduced arithmetic unit for datapaths that can tolerate latency. It accepts operands through a start/busy/done handshake and adds subtraction, which the combinational adder does not provide.

## Interface
- SLICE, 4, bits per cycle; fixed at 4. A 16-bit op takes 16/SLICE = 4 compute cycles.
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = add (a + b + cin); 1 = subtract (a - b - cin).
- a  in  16  operand A; captured on the accepting edge.
- b  in  16  operand B; captured on the accepting edge.
- cin  in  1  carry-in for add, borrow-in for subtract; captured on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result/cout/ovf are valid.
- result  out  16  final sum/difference; holds until the next completion.
- cout  out  1  raw carry out of bit 15. For subtract, 1 means no borrow (unsigned a >= b + cin).
- ovf  out  1  two's-complement signed overflow of the final result.

## Operation
- Two states: IDLE and RUN. A 2-bit slice counter cnt is used in RUN.
- IDLE with start=1: latch a, latch b' (= b for add, ~b for subtract), latch the initial carry (cin for add, ~cin for subtract), cnt=0, go to RUN, busy=1.
- IDLE with start=0: no change.
- RUN: each edge computes slice cnt with a 4-bit CLA:
  - bits [4*cnt+3 : 4*cnt] of a + b' + carry go into the internal accumulator.
  - The slice carry-out goes into the carry flop.
  - cnt increments.
- RUN with cnt==3: that edge completes the operation:
  - Copy the full accumulator, including the top slice, to result.
  - cout = top slice carry-out.
  - ovf = (a[15] == b'[15]) && (result[15] != a[15]), using latched values.
  - done=1, busy=0, go to IDLE.
- start during RUN is ignored and not queued. Operand changes during RUN have no effect.
- result, cout and ovf change only on a completion edge. Partial slices are never visible on the outputs.
- Arithmetic is modulo 2^16. The carry beyond cout is discarded.
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE, cnt=0.
  - busy=0, done=0, result=16'h0000, cout=0, ovf=0.
  - accumulator, carry and latched operands are cleared.
  - An in-flight operation is abandoned with no done pulse.

## Timing
- Accepting edge E0 (IDLE, start=1): busy=1 after E0.
- Slices 0..3 are computed on edges E1..E4.
- After E4: done=1, busy=0, and result/cout/ovf are valid. Latency is 4 cycles from acceptance.
- done is cleared on E5.
- done and busy are never high together.
- start=1 in the cycle where done=1 (state IDLE) is accepted at E5. Back-to-back throughput is one op per 5 cycles.
- start held high continuously gives ops at E0, E5, E10, …
- rst_n deassertion is synchronised by the system. The first start can be accepted on the first edge after release.

## Test plan
- Reset, then add 0x0001 + 0x0001, cin=1 -> after 4 cycles done pulse; result=0x0003, cout=0, ovf=0; busy high exactly 4 cycles.
- Add 0xFFF6 + 0xFFFC, cin=1 -> result=0xFFF3, cout=1, ovf=0.
- Add 0x7FFE + 0x7FF1, cin=1 -> result=0xFFF0, cout=0, ovf=1.
- Add 0xFFFF + 0xFFFF, cin=1 -> result=0xFFFF, cout=1, ovf=0.
- Subtract 0x0005 - 0x0007, cin=0 -> result=0xFFFE, cout=0 (borrow).
- Subtract 0x8000 - 0x0001, cin=0 -> result=0x7FFF, cout=1, ovf=1.
- Back-to-back and reset:
  - Hold start=1 with new operands after each done -> done every 5 cycles.
  - start pulses and operand changes during RUN are ignored.
  - Assert rst_n=0 at E2 of an op -> all outputs 0 immediately, no done.
  - The next op after reset is computed correctly.

Source files
------------

// File: rtl/seq_addsub_16.sv
// Area-reduced 16-bit adder/subtractor: one 4-bit carry-lookahead slice per
// clock, carry rippled through a flop, start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last completed result
//   RUN   | computing slice cnt_q (0..3); slice 3 completes the operation
module seq_addsub_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        cout_o,
  output logic        ovf_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        carry_q, carry_d;
  logic [11:0] acc_q, acc_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  sl_a, sl_b, sl_g, sl_p, sl_sum;
  logic [4:0]  sl_c;

  always_comb begin
    sl_a    = a_q[{cnt_q, 2'b00} +: 4];
    sl_b    = b_q[{cnt_q, 2'b00} +: 4];
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a ^ sl_b;
    sl_c[0] = carry_q;
    sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_sum  = sl_p ^ sl_c[3:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // Subtraction is a + ~b + ~borrow, so invert b and cin up front.
          a_d     = a_i;
          b_d     = op_i ? ~b_i : b_i;
          carry_d = cin_i ^ op_i;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = sl_c[4];
        cnt_d   = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: acc_d[3:0]  = sl_sum;
          2'd1: acc_d[7:4]  = sl_sum;
          2'd2: acc_d[11:8] = sl_sum;
          default: begin
            // Top slice bypasses the accumulator straight into the result.
            result_d = {sl_sum, acc_q};
            cout_d   = sl_c[4];
            ovf_d    = (a_q[15] == b_q[15]) && (sl_sum[3] != a_q[15]);
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      carry_q  <= 1'b0;
      acc_q    <= 12'h000;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o   = (state_q == RUN);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule
